// File: rtl/reg_file_mp.sv
// Multi-ported register file: combinational reads, prioritised writes, background clear sweep.
// Optional same-cycle write-to-read bypass when RF_BYPASS_EN is defined.
module reg_file_mp #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned NUM_RD = 5,
  parameter int unsigned NUM_WR = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_RD*((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_W-1:0]    rd_data_o,
  input  logic [NUM_WR-1:0]           wr_en_i,
  input  logic [NUM_WR*((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_W-1:0]    wr_data_i,
  input  logic                        clr_req_i,
  output logic                        clr_busy_o,
  output logic                        clr_done_o,
  output logic [NUM_WR-1:0]           wr_drop_o
);

  localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {IDLE, SWEEP} state_e;

  state_e              state_q;
  logic [ADDR_W-1:0]   cnt_q;
  logic                done_q;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                busy;
  logic [ADDR_W-1:0]   wa [NUM_WR];
  logic [DATA_W-1:0]   wd [NUM_WR];
  logic [NUM_WR-1:0]   wr_acc;

  assign busy       = (state_q == SWEEP);
  assign clr_busy_o = busy;
  assign clr_done_o = done_q;
  assign wr_drop_o  = wr_en_i & {NUM_WR{busy}};

  // Unpack write ports (port 0 in the most significant slice) and qualify them
  always_comb begin
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      wa[j]     = wr_addr_i[(NUM_WR-1-j)*ADDR_W +: ADDR_W];
      wd[j]     = wr_data_i[(NUM_WR-1-j)*DATA_W +: DATA_W];
      wr_acc[j] = wr_en_i[j] && !busy && (32'(wa[j]) < DEPTH);
    end
  end

  // Clear sweep control: counter walks 0..DEPTH-1, done pulses during the last entry
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (clr_req_i) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            done_q  <= (DEPTH == 1);
          end
        end
        SWEEP: begin
          if (cnt_q == ADDR_W'(DEPTH-1)) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q + ADDR_W'(1);
            done_q <= (cnt_q == ADDR_W'(DEPTH-2));
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Storage: sweep owns the array while busy; later write ports override earlier ones
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned e = 0; e < DEPTH; e++) mem_q[e] <= '0;
    end else if (busy) begin
      mem_q[cnt_q] <= '0;
    end else begin
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_acc[j]) mem_q[wa[j]] <= wd[j];
      end
    end
  end

  // Combinational read ports; out-of-range addresses read as zero
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] val;
    rd_data_o = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra  = rd_addr_i[(NUM_RD-1-i)*ADDR_W +: ADDR_W];
      val = '0;
      if (32'(ra) < DEPTH) val = mem_q[ra];
`ifdef RF_BYPASS_EN
      for (int unsigned j = 0; j < NUM_WR; j++) begin
        if (wr_acc[j] && (wa[j] == ra)) val = wd[j];
      end
`endif
      rd_data_o[(NUM_RD-1-i)*DATA_W +: DATA_W] = val;
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: stimulus queues expected values per cycle, a negedge monitor checks them.
module tb_reg_file_mp;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned DEPTH  = 128;
  localparam int unsigned NUM_RD = 5;
  localparam int unsigned NUM_WR = 2;
  localparam int unsigned ADDR_W = 7;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  localparam int K_RD   = 0;
  localparam int K_BUSY = 1;
  localparam int K_DONE = 2;
  localparam int K_DROP = 3;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     clr_req;
  logic                     clr_busy;
  logic                     clr_done;
  logic [NUM_WR-1:0]        wr_drop;

  typedef struct {
    int                cyc;
    int                kind;
    int                port;
    logic [DATA_W-1:0] val;
  } exp_t;

  exp_t q[$];
  int   cyc     = 0;
  int   n_vec   = 0;
  int   n_err   = 0;

  reg_file_mp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .clr_req_i  (clr_req),
    .clr_busy_o (clr_busy),
    .clr_done_o (clr_done),
    .wr_drop_o  (wr_drop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] fill_val(int a);
    return {96'h0, 32'h1000_0000 + 32'(a)};
  endfunction

  function automatic logic [DATA_W-1:0] actual(int kind, int port);
    case (kind)
      K_RD:    return rd_data[(NUM_RD-1-port)*DATA_W +: DATA_W];
      K_BUSY:  return DATA_W'(clr_busy);
      K_DONE:  return DATA_W'(clr_done);
      default: return DATA_W'(wr_drop);
    endcase
  endfunction

  function automatic string kname(int kind);
    case (kind)
      K_RD:    return "rd_data";
      K_BUSY:  return "clr_busy";
      K_DONE:  return "clr_done";
      default: return "wr_drop";
    endcase
  endfunction

  // Monitor: compare every expectation scheduled for the current cycle
  always @(negedge clk) begin
    exp_t              e;
    logic [DATA_W-1:0] act;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e   = q.pop_front();
      act = actual(e.kind, e.port);
      n_vec++;
      if (e.cyc != cyc || act !== e.val) begin
        n_err++;
        $display("FAIL %s port %0d cycle %0d (checked at %0d): got %h want %h",
                 kname(e.kind), e.port, e.cyc, cyc, act, e.val);
      end
    end
  end

  task automatic push_exp(int kind, int port, logic [DATA_W-1:0] v);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.port = port;
    e.val  = v;
    q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en   = '0;
    clr_req = 1'b0;
  endtask

  task automatic set_rd(int p, int a);
    rd_addr[(NUM_RD-1-p)*ADDR_W +: ADDR_W] = ADDR_W'(a);
  endtask

  task automatic set_wr(int p, int a, logic [DATA_W-1:0] d);
    wr_en[p] = 1'b1;
    wr_addr[(NUM_WR-1-p)*ADDR_W +: ADDR_W] = ADDR_W'(a);
    wr_data[(NUM_WR-1-p)*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    logic [DATA_W-1:0] a5;
    a5      = {16{8'hA5}};
    rst_n   = 1'b0;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    idle();
    step();
    step();

    // Reset state
    set_rd(0, 5);
    push_exp(K_RD, 0, '0);
    push_exp(K_BUSY, 0, '0);
    push_exp(K_DONE, 0, '0);
    push_exp(K_DROP, 0, '0);

    // First write right after reset release
    step();
    rst_n = 1'b1;
    set_wr(0, 5, a5);
    set_rd(2, 5);
    push_exp(K_RD, 2, BYP ? a5 : '0);
    push_exp(K_DROP, 0, '0);
    step();
    idle();
    push_exp(K_RD, 2, a5);

    // Same-address collision: higher port wins, no drop
    step();
    set_wr(0, 9, 128'h1);
    set_wr(1, 9, 128'h2);
    push_exp(K_DROP, 0, '0);
    step();
    idle();
    set_rd(1, 9);
    push_exp(K_RD, 1, 128'h2);

    // Read-during-write
    step();
    set_wr(1, 3, 128'h7);
    set_rd(3, 3);
    push_exp(K_RD, 3, BYP ? 128'h7 : '0);
    step();
    idle();
    push_exp(K_RD, 3, 128'h7);

    // Fill every entry, two per cycle
    for (int a = 0; a < int'(DEPTH); a += 2) begin
      step();
      set_wr(0, a, fill_val(a));
      set_wr(1, a + 1, fill_val(a + 1));
    end
    step();
    idle();
    set_rd(0, 0);
    set_rd(4, 127);
    push_exp(K_RD, 0, fill_val(0));
    push_exp(K_RD, 4, fill_val(127));
    clr_req = 1'b1;
    push_exp(K_BUSY, 0, '0);

    // Sweep: one entry per cycle, busy throughout, done on the last
    for (int k = 0; k < int'(DEPTH); k++) begin
      step();
      idle();
      set_rd(0, k);
      push_exp(K_RD, 0, fill_val(k));
      if (k > 0) begin
        set_rd(1, k - 1);
        push_exp(K_RD, 1, '0);
      end
      push_exp(K_BUSY, 0, 128'h1);
      push_exp(K_DONE, 0, (k == int'(DEPTH) - 1) ? 128'h1 : 128'h0);
      if (k == 10) begin
        set_wr(0, 120, '1);
        set_rd(2, 120);
        push_exp(K_RD, 2, fill_val(120));
        push_exp(K_DROP, 0, 128'h1);
      end
      if (k == 20) begin
        set_wr(0, 30, '1);
        set_wr(1, 31, '1);
        push_exp(K_DROP, 0, 128'h3);
      end
      if (k == 50) clr_req = 1'b1;
    end
    step();
    idle();
    push_exp(K_BUSY, 0, '0);
    push_exp(K_DONE, 0, '0);
    set_rd(0, 127);
    set_rd(2, 120);
    set_rd(3, 5);
    push_exp(K_RD, 0, '0);
    push_exp(K_RD, 2, '0);
    push_exp(K_RD, 3, '0);

    // Write together with clr_req commits, then reset aborts the sweep at count 40
    step();
    set_wr(0, 100, 128'h77);
    step();
    idle();
    set_wr(0, 60, 128'h55);
    clr_req = 1'b1;
    push_exp(K_BUSY, 0, '0);
    push_exp(K_DROP, 0, '0);
    for (int k = 0; k <= 40; k++) begin
      step();
      idle();
      set_rd(0, 60);
      set_rd(1, 100);
      if (k == 40) begin
        rst_n = 1'b0;
        push_exp(K_RD, 0, '0);
        push_exp(K_RD, 1, '0);
        push_exp(K_BUSY, 0, '0);
        push_exp(K_DONE, 0, '0);
      end else begin
        push_exp(K_RD, 0, 128'h55);
        push_exp(K_RD, 1, 128'h77);
        push_exp(K_BUSY, 0, 128'h1);
      end
    end
    for (int k = 0; k < 3; k++) begin
      step();
      push_exp(K_DONE, 0, '0);
      push_exp(K_BUSY, 0, '0);
    end
    step();
    rst_n = 1'b1;
    set_wr(1, 7, 128'hBEEF);
    push_exp(K_DROP, 0, '0);
    step();
    idle();
    set_rd(4, 7);
    push_exp(K_RD, 4, 128'hBEEF);
    push_exp(K_BUSY, 0, '0);

    step();
    step();
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 SHALL expose parameter DATA_W, default 128, bits per entry.
REQ-002 SHALL expose parameter DEPTH, default 128, number of entries; ADDR_W = ceil(log2(DEPTH)).
REQ-003 SHALL expose parameter NUM_RD, default 5, number of read ports.
REQ-004 SHALL expose parameter NUM_WR, default 2, number of write ports.
REQ-005 Ports: clock  in  1  sole clock, rising edge.
REQ-006 Ports: reset  in  1  asynchronous, active-low reset (one clock; reset asynchronous and active-low).
REQ-007 Ports: rd_addr  in  NUM_RD*ADDR_W  read addresses, port 0 in the most significant slice.
REQ-008 Ports: rd_data  out  NUM_RD*DATA_W  read data, same slice order as rd_addr.
REQ-009 Ports: wr_en  in  NUM_WR  per-port write enable.
REQ-010 Ports: wr_addr  in  NUM_WR*ADDR_W  write addresses.
REQ-011 Ports: wr_data  in  NUM_WR*DATA_W  write data.
REQ-012 Ports: clr_req  in  1  single-cycle pulse that starts a background clear sweep.
REQ-013 Ports: clr_busy  out  1  high while the sweep is in progress.
REQ-014 Ports: clr_done  out  1  one-cycle pulse on the cycle the last entry is cleared.
REQ-015 Ports: wr_drop  out  NUM_WR  per-port pulse, write rejected this cycle.

Function
REQ-016 Reads SHALL be combinational: rd_data[i] = entry[rd_addr[i]] with zero-cycle latency.
REQ-017 Writes SHALL commit on the rising clock edge when wr_en[j]=1 and clr_busy=0.
REQ-018 On a same-cycle write to the same address from two ports, the higher-index port SHALL win; the lower-index port is silently overwritten and does not pulse wr_drop.
REQ-019 Addresses >= DEPTH SHALL be ignored on write; on read they SHALL return zero.
REQ-020 Clear FSM states SHALL be IDLE and SWEEP; IDLE->SWEEP on clr_req=1; SWEEP->IDLE after entry DEPTH-1 is zeroed.
REQ-021 In SWEEP, a counter starting at 0 SHALL zero one entry per cycle, so the sweep takes exactly DEPTH cycles; clr_busy=1 throughout SWEEP.
REQ-022 clr_done SHALL pulse for one cycle, coincident with the edge that clears entry DEPTH-1; clr_busy SHALL be 0 in the following cycle.
REQ-023 clr_req while in SWEEP SHALL be ignored; the counter SHALL NOT restart.
REQ-024 While clr_busy=1, any wr_en[j]=1 SHALL be dropped and wr_drop[j] SHALL pulse for that cycle.
REQ-025 During SWEEP, reads SHALL return current array contents: zero for swept entries, old data for entries not yet swept.
REQ-026 clr_req together with wr_en in an IDLE cycle: the write SHALL commit, and the sweep SHALL begin next cycle and clear it.

Reset
REQ-027 Assertion of reset (low) SHALL immediately zero all entries, force the FSM to IDLE, zero the sweep counter, and drive clr_busy=0, clr_done=0 and wr_drop=0, independent of clock.
REQ-028 Reset asserted mid-sweep SHALL abort the sweep with no clr_done pulse.
REQ-029 The first write SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-030 Macro RF_BYPASS_EN: when defined, a read whose address matches a same-cycle accepted write SHALL return that write's data (highest-index matching port); when undefined, it SHALL return the pre-write stored value.
REQ-031 With RF_BYPASS_EN defined, no bypass SHALL occur for dropped writes or during SWEEP.

Verification
REQ-032 Reset, then write port0 addr 5 = 0xA5A5..A5; next cycle read port2 addr 5 -> 0xA5A5..A5.
REQ-033 Both write ports target addr 9 (port0 = 0x1, port1 = 0x2) -> next cycle addr 9 reads 0x2.
REQ-034 Write addr 3 = 0x7 and read addr 3 in the same cycle -> read shows 0x7 with RF_BYPASS_EN, 0x0 without.
REQ-035 Fill all entries, pulse clr_req -> clr_busy high for 128 cycles, clr_done on the 128th, all reads 0 afterwards; a write during the sweep pulses wr_drop and is lost.
REQ-036 Assert reset at sweep count 40 -> all entries 0 at once, clr_busy 0, no clr_done; a write after deassertion succeeds.
